// File: rtl/pipe_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_pkg : shared forward-select codes, stall-run states, ID/EX control bundle
// Rev 1.0
// ------------------------------------------------------------------
package pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_ME = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_OVER = 2'd3
  } stall_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [4:0] write_reg;
    logic [3:0] alu_ctrl;
    logic [2:0] pc_src;
  } idex_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ------------------------------------------------------------------
// fwd_mux : 32-bit operand forward select (RF / EX / ME); code 11 falls back to RF
// Rev 1.0
// ------------------------------------------------------------------
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_rf,
  input  logic [31:0] i_ex,
  input  logic [31:0] i_me,
  output logic [31:0] o_q
);

  always_comb begin
    o_q = i_rf;
    case (i_sel)
      FWD_EX:  o_q = i_ex;
      FWD_ME:  o_q = i_me;
      default: o_q = i_rf;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// id_ex_pipe : ID/EX pipeline register with forwarding, bubbles and stall watchdog
// Rev 1.0
// ------------------------------------------------------------------
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       ID_FA,
  input  logic [1:0]       ID_FB,
  input  logic [31:0]      ID_rd1,
  input  logic [31:0]      ID_rd2,
  input  logic [31:0]      EX_fwd,
  input  logic [31:0]      ME_fwd,
  input  logic             ID_RegWrite,
  input  logic             ID_MemtoReg,
  input  logic             ID_MemWrite,
  input  logic [4:0]       ID_WriteReg,
  input  logic [3:0]       ID_ALUCtrl,
  input  logic [2:0]       ID_PCSrc,
  input  logic [31:0]      ID_Imm,
  input  logic [31:0]      ID_PC,
  output logic [31:0]      EX_A,
  output logic [31:0]      EX_B,
  output logic             EX_RegWrite,
  output logic             EX_MemtoReg,
  output logic             EX_MemWrite,
  output logic [4:0]       EX_WriteReg,
  output logic [3:0]       EX_ALUCtrl,
  output logic [2:0]       EX_PCSrc,
  output logic [31:0]      EX_Imm,
  output logic [31:0]      EX_PC,
  output logic             EX_valid,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             stall_err
);

  idex_ctrl_t       r_ctrl;
  idex_ctrl_t       w_id_ctrl;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_imm;
  logic [31:0]      r_pc;
  logic             r_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  stall_state_e     r_state;
  stall_state_e     w_state_nxt;
  logic             w_bubble;
  logic             w_set_err;

  fwd_mux u_fwd_a (
    .i_sel (ID_FA),
    .i_rf  (ID_rd1),
    .i_ex  (EX_fwd),
    .i_me  (ME_fwd),
    .o_q   (w_a)
  );

  fwd_mux u_fwd_b (
    .i_sel (ID_FB),
    .i_rf  (ID_rd2),
    .i_ex  (EX_fwd),
    .i_me  (ME_fwd),
    .o_q   (w_b)
  );

  // Stall and flush together still make exactly one bubble.
  assign w_bubble = stall | flush;

  assign w_id_ctrl = '{
    reg_write:  ID_RegWrite,
    mem_to_reg: ID_MemtoReg,
    mem_write:  ID_MemWrite,
    write_reg:  ID_WriteReg,
    alu_ctrl:   ID_ALUCtrl,
    pc_src:     ID_PCSrc
  };

  always_comb begin
    w_state_nxt = r_state;
    w_set_err   = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (stall) w_state_nxt = ST_S1;
        ST_S1:   w_state_nxt = stall ? ST_S2 : ST_IDLE;
        ST_S2: begin
          if (stall) begin
            w_state_nxt = ST_OVER;
            w_set_err   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_OVER: w_state_nxt = stall ? ST_OVER : ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_set_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_bubble) begin
      r_ctrl  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_ctrl  <= w_id_ctrl;
      r_a     <= w_a;
      r_b     <= w_b;
      r_imm   <= ID_Imm;
      r_pc    <= ID_PC;
      r_valid <= 1'b1;
    end
  end

  assign EX_A        = r_a;
  assign EX_B        = r_b;
  assign EX_RegWrite = r_ctrl.reg_write;
  assign EX_MemtoReg = r_ctrl.mem_to_reg;
  assign EX_MemWrite = r_ctrl.mem_write;
  assign EX_WriteReg = r_ctrl.write_reg;
  assign EX_ALUCtrl  = r_ctrl.alu_ctrl;
  assign EX_PCSrc    = r_ctrl.pc_src;
  assign EX_Imm      = r_imm;
  assign EX_PC       = r_pc;
  assign EX_valid    = r_valid;
  assign bubble_cnt  = r_cnt;
  assign stall_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_id_ex_pipe : directed vector table, saturation sequence and random model check
// Rev 1.0
// ------------------------------------------------------------------
module tb_id_ex_pipe;

  logic        clk;
  logic        rst, stall, flush;
  logic [1:0]  ID_FA, ID_FB;
  logic [31:0] ID_rd1, ID_rd2, EX_fwd, ME_fwd;
  logic        ID_RegWrite, ID_MemtoReg, ID_MemWrite;
  logic [4:0]  ID_WriteReg;
  logic [3:0]  ID_ALUCtrl;
  logic [2:0]  ID_PCSrc;
  logic [31:0] ID_Imm, ID_PC;

  logic [31:0] EX_A, EX_B, EX_Imm, EX_PC;
  logic        EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_valid, stall_err;
  logic [4:0]  EX_WriteReg;
  logic [3:0]  EX_ALUCtrl;
  logic [2:0]  EX_PCSrc;
  logic [15:0] bubble_cnt;

  logic [31:0] s_A, s_B, s_Imm, s_PC;
  logic        s_RegWrite, s_MemtoReg, s_MemWrite, s_valid, s_err;
  logic [4:0]  s_WriteReg;
  logic [3:0]  s_ALUCtrl;
  logic [2:0]  s_PCSrc;
  logic [3:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  id_ex_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ID_FA(ID_FA), .ID_FB(ID_FB), .ID_rd1(ID_rd1), .ID_rd2(ID_rd2),
    .EX_fwd(EX_fwd), .ME_fwd(ME_fwd),
    .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_MemWrite(ID_MemWrite),
    .ID_WriteReg(ID_WriteReg), .ID_ALUCtrl(ID_ALUCtrl), .ID_PCSrc(ID_PCSrc),
    .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .EX_A(EX_A), .EX_B(EX_B), .EX_RegWrite(EX_RegWrite), .EX_MemtoReg(EX_MemtoReg),
    .EX_MemWrite(EX_MemWrite), .EX_WriteReg(EX_WriteReg), .EX_ALUCtrl(EX_ALUCtrl),
    .EX_PCSrc(EX_PCSrc), .EX_Imm(EX_Imm), .EX_PC(EX_PC), .EX_valid(EX_valid),
    .bubble_cnt(bubble_cnt), .stall_err(stall_err)
  );

  id_ex_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ID_FA(ID_FA), .ID_FB(ID_FB), .ID_rd1(ID_rd1), .ID_rd2(ID_rd2),
    .EX_fwd(EX_fwd), .ME_fwd(ME_fwd),
    .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_MemWrite(ID_MemWrite),
    .ID_WriteReg(ID_WriteReg), .ID_ALUCtrl(ID_ALUCtrl), .ID_PCSrc(ID_PCSrc),
    .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .EX_A(s_A), .EX_B(s_B), .EX_RegWrite(s_RegWrite), .EX_MemtoReg(s_MemtoReg),
    .EX_MemWrite(s_MemWrite), .EX_WriteReg(s_WriteReg), .EX_ALUCtrl(s_ALUCtrl),
    .EX_PCSrc(s_PCSrc), .EX_Imm(s_Imm), .EX_PC(s_PC), .EX_valid(s_valid),
    .bubble_cnt(s_cnt), .stall_err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: expected EX contents plus bubble totals and stall-run length.
  logic [31:0] m_a, m_b, m_imm, m_pc;
  logic        m_rw, m_mr, m_mw, m_v, m_err;
  logic [4:0]  m_wr;
  logic [3:0]  m_alu;
  logic [2:0]  m_pcs;
  int          m_cnt, m_cnt4, m_run;

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf,
                                       input logic [31:0] ex, input logic [31:0] me);
    if (s == 2'b01) return ex;
    if (s == 2'b10) return me;
    return rf;
  endfunction

  task automatic model_edge();
    if (rst) begin
      {m_a, m_b, m_imm, m_pc} = '0;
      {m_rw, m_mr, m_mw, m_v, m_err} = '0;
      m_wr = '0; m_alu = '0; m_pcs = '0;
      m_cnt = 0; m_cnt4 = 0; m_run = 0;
    end else if (stall || flush) begin
      {m_a, m_b, m_imm, m_pc} = '0;
      {m_rw, m_mr, m_mw, m_v} = '0;
      m_wr = '0; m_alu = '0; m_pcs = '0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
      m_run = (stall && !flush) ? m_run + 1 : 0;
      if (m_run > 2) m_err = 1'b1;
    end else begin
      m_a = pick(ID_FA, ID_rd1, EX_fwd, ME_fwd);
      m_b = pick(ID_FB, ID_rd2, EX_fwd, ME_fwd);
      m_rw = ID_RegWrite; m_mr = ID_MemtoReg; m_mw = ID_MemWrite; m_v = 1'b1;
      m_wr = ID_WriteReg; m_alu = ID_ALUCtrl; m_pcs = ID_PCSrc;
      m_imm = ID_Imm; m_pc = ID_PC;
      m_run = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input int cyc);
    string p;
    p = $sformatf("rnd%0d", cyc);
    chk({p, ".A"}, EX_A, m_a);
    chk({p, ".B"}, EX_B, m_b);
    chk({p, ".RegWrite"}, 32'(EX_RegWrite), 32'(m_rw));
    chk({p, ".MemtoReg"}, 32'(EX_MemtoReg), 32'(m_mr));
    chk({p, ".MemWrite"}, 32'(EX_MemWrite), 32'(m_mw));
    chk({p, ".WriteReg"}, 32'(EX_WriteReg), 32'(m_wr));
    chk({p, ".ALUCtrl"}, 32'(EX_ALUCtrl), 32'(m_alu));
    chk({p, ".PCSrc"}, 32'(EX_PCSrc), 32'(m_pcs));
    chk({p, ".Imm"}, EX_Imm, m_imm);
    chk({p, ".PC"}, EX_PC, m_pc);
    chk({p, ".valid"}, 32'(EX_valid), 32'(m_v));
    chk({p, ".bubble_cnt"}, 32'(bubble_cnt), 32'(m_cnt));
    chk({p, ".stall_err"}, 32'(stall_err), 32'(m_err));
    chk({p, ".cnt4"}, 32'(s_cnt), 32'(m_cnt4));
    chk({p, ".err4"}, 32'(s_err), 32'(m_err));
  endtask

  typedef struct {
    bit          r, s, f;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, exf, mef;
    bit          rw;
    logic [4:0]  wr;
    logic [31:0] ea, eb;
    bit          ev;
    logic [4:0]  ewr;
    bit          erw;
    int          ecnt;
    bit          eerr;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit f, logic [1:0] fa, logic [1:0] fb,
                              logic [31:0] rd1, logic [31:0] rd2, logic [31:0] exf,
                              logic [31:0] mef, bit rw, logic [4:0] wr,
                              logic [31:0] ea, logic [31:0] eb, bit ev, logic [4:0] ewr,
                              bit erw, int ecnt, bit eerr);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.fa = fa; v.fb = fb;
    v.rd1 = rd1; v.rd2 = rd2; v.exf = exf; v.mef = mef; v.rw = rw; v.wr = wr;
    v.ea = ea; v.eb = eb; v.ev = ev; v.ewr = ewr; v.erw = erw; v.ecnt = ecnt; v.eerr = eerr;
    return v;
  endfunction

  vec_t tbl[$];

  task automatic apply(input vec_t v);
    rst = v.r; stall = v.s; flush = v.f;
    ID_FA = v.fa; ID_FB = v.fb;
    ID_rd1 = v.rd1; ID_rd2 = v.rd2; EX_fwd = v.exf; ME_fwd = v.mef;
    ID_RegWrite = v.rw; ID_WriteReg = v.wr;
    ID_MemtoReg = 1'b1; ID_MemWrite = 1'b1; ID_ALUCtrl = 4'h5; ID_PCSrc = 3'h2;
    ID_Imm = 32'h0000_0100; ID_PC = 32'h0000_4000;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    ID_FA = '0; ID_FB = '0; ID_rd1 = '0; ID_rd2 = '0; EX_fwd = '0; ME_fwd = '0;
    ID_RegWrite = 1'b0; ID_MemtoReg = 1'b0; ID_MemWrite = 1'b0;
    ID_WriteReg = '0; ID_ALUCtrl = '0; ID_PCSrc = '0; ID_Imm = '0; ID_PC = '0;
    m_cnt = 0; m_cnt4 = 0; m_run = 0; m_err = 1'b0;

    //          r s f  fa    fb    rd1           rd2          exf          mef        rw wr   eA            eB          ev ewr erw cnt err
    tbl.push_back(mk(1,0,0, 2'b00,2'b00, 32'h1,        32'h2,       32'h3,       32'h4,        1, 5'd1, 32'h0,        32'h0,        0, 5'd0, 0, 0, 0));
    tbl.push_back(mk(0,0,0, 2'b01,2'b00, 32'hDEADBEEF, 32'h77,      32'h1234,    32'h4,        1, 5'd3, 32'h1234,     32'h77,       1, 5'd3, 1, 0, 0));
    tbl.push_back(mk(0,0,0, 2'b00,2'b10, 32'h11,       32'h22,      32'h1234,    32'hCAFE0001, 1, 5'd4, 32'h11,       32'hCAFE0001, 1, 5'd4, 1, 0, 0));
    tbl.push_back(mk(0,0,0, 2'b10,2'b11, 32'h11,       32'h5,       32'h1234,    32'hCAFE0001, 0, 5'd9, 32'hCAFE0001, 32'h5,        1, 5'd9, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 1, 0));
    tbl.push_back(mk(0,0,0, 2'b00,2'b00, 32'hA,        32'hB,       32'h33,      32'h44,       0, 5'd0, 32'hA,        32'hB,        1, 5'd0, 0, 1, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 2, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 3, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 4, 1));
    tbl.push_back(mk(0,0,0, 2'b00,2'b01, 32'h99,       32'h22,      32'h55,      32'h44,       1, 5'd7, 32'h99,       32'h55,       1, 5'd7, 1, 4, 1));
    tbl.push_back(mk(0,1,1, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 5, 1));
    tbl.push_back(mk(1,0,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 1, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 2, 0));
    tbl.push_back(mk(1,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 1, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 2, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 3, 1));
    tbl.push_back(mk(1,0,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 0, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 1, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 2, 0));
    tbl.push_back(mk(0,1,1, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 3, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 4, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 5, 0));
    tbl.push_back(mk(0,1,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 6, 1));
    tbl.push_back(mk(1,0,0, 2'b00,2'b00, 32'h11,       32'h22,      32'h33,      32'h44,       1, 5'd8, 32'h0,        32'h0,        0, 5'd0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      step();
      chk($sformatf("vec%0d.A", i), EX_A, tbl[i].ea);
      chk($sformatf("vec%0d.B", i), EX_B, tbl[i].eb);
      chk($sformatf("vec%0d.valid", i), 32'(EX_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.WriteReg", i), 32'(EX_WriteReg), 32'(tbl[i].ewr));
      chk($sformatf("vec%0d.RegWrite", i), 32'(EX_RegWrite), 32'(tbl[i].erw));
      chk($sformatf("vec%0d.bubble_cnt", i), 32'(bubble_cnt), 32'(tbl[i].ecnt));
      chk($sformatf("vec%0d.stall_err", i), 32'(stall_err), 32'(tbl[i].eerr));
    end

    // Narrow counter: 15 bubbles reach all-ones, further bubbles must hold.
    stall = 1'b1; flush = 1'b1; rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 15) begin
        chk("sat.cnt4_at15", 32'(s_cnt), 32'd15);
        chk("sat.cnt16_at15", 32'(bubble_cnt), 32'd15);
      end
    end
    chk("sat.cnt4_hold", 32'(s_cnt), 32'd15);
    chk("sat.cnt16_17", 32'(bubble_cnt), 32'd17);
    chk("sat.err", 32'(stall_err), 32'd0);
    chk("sat.valid4", 32'(s_valid), 32'd0);

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    step();
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      ID_FA = 2'($urandom_range(0, 3));
      ID_FB = 2'($urandom_range(0, 3));
      ID_rd1 = $urandom; ID_rd2 = $urandom; EX_fwd = $urandom; ME_fwd = $urandom;
      ID_RegWrite = 1'($urandom); ID_MemtoReg = 1'($urandom); ID_MemWrite = 1'($urandom);
      ID_WriteReg = 5'($urandom); ID_ALUCtrl = 4'($urandom); ID_PCSrc = 3'($urandom);
      ID_Imm = $urandom; ID_PC = $urandom;
      step();
      chk_model(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter CNT_W, default 16, width of the bubble counter.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 stall  in  1  load-use/branch hazard stall from the ID-stage hazard unit.
REQ-005 flush  in  1  redirect taken; kill the instruction currently in ID.
REQ-006 ID_FA, ID_FB  in  2 each  operand A/B forward select.
REQ-007 ID_rd1, ID_rd2  in  32 each  register-file read data.
REQ-008 EX_fwd  in  32  ALU result now in EX; ME_fwd  in  32  result now in ME.
REQ-009 ID_RegWrite, ID_MemtoReg, ID_MemWrite  in  1 each; ID_WriteReg  in  5; ID_ALUCtrl  in  4; ID_PCSrc  in  3; ID_Imm, ID_PC  in  32 each  decoded ID fields.
REQ-010 EX_A, EX_B  out  32 each  latched, forwarded operands.
REQ-011 EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_WriteReg, EX_ALUCtrl, EX_PCSrc, EX_Imm, EX_PC  out  latched copies of the ID fields (same widths).
REQ-012 EX_valid  out  1  EX holds a real instruction.
REQ-013 bubble_cnt  out  CNT_W  count of bubbles inserted.
REQ-014 stall_err  out  1  sticky flag: stall held longer than 2 consecutive cycles.

Function
REQ-015 Operand select: 00 -> ID_rd1/ID_rd2; 01 -> EX_fwd; 10 -> ME_fwd; 11 -> register-file data (reserved code).
REQ-016 All outputs update only on a rising clk edge; latency ID -> EX is exactly 1 cycle.
REQ-017 Per-edge priority: rst > flush > stall > normal load.
REQ-018 Normal load (stall=0, flush=0): capture all ID fields, selected operands, and EX_valid=1.
REQ-019 Bubble (flush=1, or stall=1 without flush): EX_RegWrite, EX_MemtoReg, EX_MemWrite, EX_valid = 0; EX_WriteReg = 0; EX_PCSrc = 0; EX_ALUCtrl = 0; data fields (EX_A, EX_B, EX_Imm, EX_PC) = 0.
REQ-020 bubble_cnt increments by 1 on every bubble edge; saturates at all-ones and holds.
REQ-021 Stall-run FSM states: IDLE, S1, S2, OVER.
REQ-022 IDLE: stall=1 -> S1; otherwise stay.
REQ-023 S1: stall=1 -> S2; stall=0 -> IDLE.
REQ-024 S2: stall=1 -> OVER and set stall_err; stall=0 -> IDLE.
REQ-025 OVER: stall=1 -> stay; stall=0 -> IDLE. stall_err stays set until rst.
REQ-026 A flush forces the FSM to IDLE regardless of stall.
REQ-027 Simultaneous stall and flush produce a single bubble and a single increment.

Reset
REQ-028 On rst=1 at an edge: all EX_* outputs = 0, EX_valid = 0, bubble_cnt = 0, stall_err = 0, FSM = IDLE.
REQ-029 Reset asserted mid-stall discards the stall run; the first post-reset stall enters S1.
REQ-030 A reset edge does not count as a bubble.

Structure
REQ-031 Package pipe_pkg holds FWD_RF=2'b00, FWD_EX=2'b01, FWD_ME=2'b10, the FSM state encoding, and the ID/EX control-bundle typedef.
REQ-032 Sub-module fwd_mux: 32-bit 3:1 operand select, instantiated twice (A, B).

Verification
REQ-033 ID_FA=01, EX_fwd=0x0000_1234, ID_rd1=0xDEAD_BEEF, no stall -> next edge EX_A=0x0000_1234, EX_valid=1.
REQ-034 ID_FB=10, ME_fwd=0xCAFE_0001; ID_FB=11 with ID_rd2=0x5 -> EX_B=0xCAFE_0001, then EX_B=0x5.
REQ-035 stall=1 for 1 cycle with ID_RegWrite=1, ID_WriteReg=8 -> EX_RegWrite=0, EX_WriteReg=0, EX_valid=0, bubble_cnt=1; stall_err stays 0.
REQ-036 stall=1 for 3 consecutive cycles -> bubble_cnt=3, stall_err=1 after the 3rd edge; stall_err remains 1 after stall drops, clears only on rst.
REQ-037 stall=1 and flush=1 on the same edge -> one bubble, bubble_cnt +1, FSM IDLE; CNT_W=4 preloaded to 15 plus a further bubble -> bubble_cnt stays 15.
REQ-038 rst=1 during the S2 state -> all outputs 0, FSM IDLE; a following 2-cycle stall leaves stall_err=0.
